// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: memory-stage load/store initiator driving the data memory strobe/stall interface.
// Optional macro LSU_MISALIGN_SPLIT_EN turns misaligned loads into two aligned word reads.
module lsu_dmem_master #(
    parameter int STALL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_write_data,
    output logic        dmem_memwrite,
    output logic        dmem_memread,
    output logic [3:0]  dmem_sign_mask,
    input  logic [31:0] dmem_read_data,
    input  logic        dmem_clk_stall
);
    localparam int CNT_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {IDLE, STROBE, WAIT, RESP, SPLIT2} state_t;
`else
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
`endif

    state_t           state_reg, state_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [31:0]      rdata_reg, rdata_next;
    logic [3:0]       mask_reg, mask_next;
    logic             memread_reg, memread_next;
    logic             memwrite_reg, memwrite_next;
    logic             fault_reg, fault_next;
    logic             write_reg, write_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept, bad_size, misaligned;
    logic [2:0]       size_mask;

    assign req_ready  = (state_reg == IDLE) && !dmem_clk_stall;
    assign accept     = req_valid && req_ready;
    assign bad_size   = (req_size == 2'b11);
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign size_mask  = (req_size == 2'b00) ? 3'b001 : (req_size == 2'b01) ? 3'b011 : 3'b111;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_ok;
    logic        split_reg, split_next, first_reg, first_next;
    logic        half_reg, half_next, signed_reg, signed_next;
    logic [1:0]  off_reg, off_next;
    logic [31:0] lo_reg, lo_next, split_word, split_data;

    // A half at offset 1 is not split: the memory ignores addr[0] for halves.
    assign split_ok   = !req_write && (((req_size == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)));
    assign split_word = 32'({dmem_read_data, lo_reg} >> {off_reg, 3'b000});
    assign split_data = half_reg ? {{16{signed_reg & split_word[15]}}, split_word[15:0]} : split_word;
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        mask_next     = mask_reg;
        fault_next    = fault_reg;
        write_next    = write_reg;
        cnt_next      = cnt_reg;
        memread_next  = 1'b0;
        memwrite_next = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_next    = split_reg;
        first_next    = first_reg;
        half_next     = half_reg;
        signed_next   = signed_reg;
        off_next      = off_reg;
        lo_next       = lo_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    rdata_next = '0;
                    write_next = req_write;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_next = 1'b0;
                    if (split_ok) begin
                        addr_next    = {req_addr[31:2], 2'b00};
                        wdata_next   = req_wdata;
                        mask_next    = 4'b0111;
                        memread_next = 1'b1;
                        split_next   = 1'b1;
                        first_next   = 1'b1;
                        half_next    = (req_size == 2'b01);
                        signed_next  = req_signed;
                        off_next     = req_addr[1:0];
                        fault_next   = 1'b0;
                        state_next   = STROBE;
                    end else
`endif
                    if (bad_size || misaligned) begin
                        fault_next = 1'b1;
                        state_next = RESP;
                    end else begin
                        addr_next     = req_addr;
                        wdata_next    = req_wdata;
                        mask_next     = {req_signed, size_mask};
                        memread_next  = !req_write;
                        memwrite_next = req_write;
                        fault_next    = 1'b0;
                        state_next    = STROBE;
                    end
                end
            end
            STROBE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (!dmem_clk_stall) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_reg && first_reg) begin
                        lo_next    = dmem_read_data;
                        first_next = 1'b0;
                        state_next = SPLIT2;
                    end else begin
                        if (!write_reg) rdata_next = split_reg ? split_data : dmem_read_data;
                        state_next = RESP;
                    end
`else
                    if (!write_reg) rdata_next = dmem_read_data;
                    state_next = RESP;
`endif
                end else if (cnt_reg == CNT_W'(STALL_TIMEOUT - 1)) begin
                    fault_next = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT2: begin
                addr_next    = addr_reg + 32'd4;
                memread_next = 1'b1;
                state_next   = STROBE;
            end
`endif
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            mask_reg     <= '0;
            fault_reg    <= 1'b0;
            write_reg    <= 1'b0;
            cnt_reg      <= '0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_reg    <= 1'b0;
            first_reg    <= 1'b0;
            half_reg     <= 1'b0;
            signed_reg   <= 1'b0;
            off_reg      <= '0;
            lo_reg       <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            mask_reg     <= mask_next;
            fault_reg    <= fault_next;
            write_reg    <= write_next;
            cnt_reg      <= cnt_next;
            memread_reg  <= memread_next;
            memwrite_reg <= memwrite_next;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_reg    <= split_next;
            first_reg    <= first_next;
            half_reg     <= half_next;
            signed_reg   <= signed_next;
            off_reg      <= off_next;
            lo_reg       <= lo_next;
`endif
        end
    end

    assign rsp_valid       = (state_reg == RESP);
    assign rsp_rdata       = rdata_reg;
    assign rsp_fault       = fault_reg;
    assign dmem_addr       = addr_reg;
    assign dmem_write_data = wdata_reg;
    assign dmem_sign_mask  = mask_reg;
    assign dmem_memread    = memread_reg;
    assign dmem_memwrite   = memwrite_reg;
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed vector table, hand corner sequences and randomized accesses
// against a stalling data memory model.
module tb_lsu_dmem_master;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [31:0] dmem_addr, dmem_write_data;
    logic        dmem_memwrite, dmem_memread;
    logic [3:0]  dmem_sign_mask;
    logic [31:0] dmem_read_data = '0;
    logic        dmem_clk_stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_dmem_master #(.STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
        .dmem_memwrite(dmem_memwrite), .dmem_memread(dmem_memread),
        .dmem_sign_mask(dmem_sign_mask), .dmem_read_data(dmem_read_data),
        .dmem_clk_stall(dmem_clk_stall)
    );

    // Memory model: stall rises the edge after it sees a strobe and stays up stall_len cycles.
    int          stall_len = 2;
    int          mem_cnt = 0;
    bit          strobe_seen = 1'b0;
    logic [31:0] mem_q[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cnt = 0, wr_cnt = 0, run = 0, max_run = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_mask;

    always @(negedge clk) begin
        strobe_seen = (dmem_memread === 1'b1) || (dmem_memwrite === 1'b1);
        if (strobe_seen) begin
            run++;
            if (run > max_run) max_run = run;
            cap_addr  = dmem_addr;
            cap_wdata = dmem_write_data;
            cap_mask  = dmem_sign_mask;
            if (dmem_memread) begin
                rd_cnt++;
                rd_addr_q.push_back(dmem_addr);
            end
            if (dmem_memwrite) wr_cnt++;
        end else begin
            run = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) dmem_clk_stall = 1'b0;
        end else if (strobe_seen) begin
            dmem_clk_stall = 1'b1;
            mem_cnt = stall_len;
            if (mem_q.size() != 0) dmem_read_data = mem_q.pop_front();
            else dmem_read_data = $urandom;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the access rules: alignment by modulo, latency from stall length.
    function automatic void model(input logic [31:0] a, input logic [1:0] sz, input bit sg, input int sl,
                                  output bit access, output bit fault, output int lat,
                                  output logic [3:0] mask);
        int nbytes;
        nbytes = 1 << sz;
        access = (sz != 2'd3) && ((a % nbytes) == 0);
        fault  = !access || (sl >= TO);
        lat    = !access ? 0 : ((sl >= TO) ? TO + 1 : sl + 2);
        mask   = {sg, 3'((2 << sz) - 1)};
    endfunction

    task automatic wait_ready(input string name);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_txn(input string name, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input bit sg, input int sl, input logic [31:0] mdata,
                           input bit exp_access, input bit exp_fault, input int exp_lat,
                           input logic [3:0] exp_mask, input logic [31:0] exp_rdata);
        int cyc;
        stall_len = sl;
        mem_q.delete();
        if (exp_access && !wr) mem_q.push_back(mdata);
        wait_ready(name);
        rd_cnt = 0; wr_cnt = 0; max_run = 0;
        rd_addr_q.delete();
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_signed = 1'($urandom);
        check({name, " busy"}, 32'(req_ready), 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " fault"}, 32'(rsp_fault), 32'(exp_fault));
        check({name, " rdata"}, rsp_rdata, exp_rdata);
        check({name, " nreads"}, 32'(rd_cnt), 32'(exp_access && !wr));
        check({name, " nwrites"}, 32'(wr_cnt), 32'(exp_access && wr));
        check({name, " strobe_len"}, 32'(max_run), 32'(exp_access));
        if (exp_access) begin
            check({name, " addr"}, cap_addr, a);
            check({name, " mask"}, 32'(cap_mask), 32'(exp_mask));
            check({name, " wdata"}, cap_wdata, wd);
            check({name, " addr_hold"}, dmem_addr, a);
        end
        @(posedge clk); #1;
        check({name, " pulse"}, 32'(rsp_valid), 32'd0);
        $display("txn %s wr=%0d addr=%h size=%0d stall=%0d -> lat=%0d fault=%0d rdata=%h",
                 name, wr, a, sz, sl, cyc, exp_fault, exp_rdata);
    endtask

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        bit          sgn;
        int          sl;
        logic [31:0] mdata;
        bit          exp_access;
        bit          exp_fault;
        int          exp_lat;
        logic [3:0]  exp_mask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[12];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bad, bad_rsp;
        bit wr, sg, acc, flt;
        logic [31:0] a, d, m;
        logic [1:0] sz;
        logic [3:0] mk;
        int sl, lat;

        vt[0]  = '{"ld_word",      1'b0, 32'h4004, 32'h0,        2'b10, 1'b0, 2,  32'hDEADBEEF, 1'b1, 1'b0, 4,  4'b0111, 32'hDEADBEEF};
        vt[1]  = '{"ld_sbyte",     1'b0, 32'h4006, 32'h0,        2'b00, 1'b1, 2,  32'hFFFFFF9C, 1'b1, 1'b0, 4,  4'b1001, 32'hFFFFFF9C};
        vt[2]  = '{"st_half_mis",  1'b1, 32'h4001, 32'h1234,     2'b01, 1'b0, 2,  32'h0,        1'b0, 1'b1, 0,  4'b0000, 32'h0};
        vt[3]  = '{"st_byte",      1'b1, 32'h4003, 32'hA5,       2'b00, 1'b0, 2,  32'h0,        1'b1, 1'b0, 4,  4'b0001, 32'h0};
        vt[4]  = '{"ld_uhalf",     1'b0, 32'h4002, 32'h0,        2'b01, 1'b0, 3,  32'h0000BEEF, 1'b1, 1'b0, 5,  4'b0011, 32'h0000BEEF};
        vt[5]  = '{"ld_size3",     1'b0, 32'h4000, 32'h0,        2'b11, 1'b0, 2,  32'h0,        1'b0, 1'b1, 0,  4'b0000, 32'h0};
        vt[6]  = '{"st_word_mis",  1'b1, 32'h4002, 32'hCAFEF00D, 2'b10, 1'b0, 2,  32'h0,        1'b0, 1'b1, 0,  4'b0000, 32'h0};
        vt[7]  = '{"ld_half_off1", 1'b0, 32'h4001, 32'h0,        2'b01, 1'b1, 2,  32'h0,        1'b0, 1'b1, 0,  4'b0000, 32'h0};
        vt[8]  = '{"ld_word_fast", 1'b0, 32'h4000, 32'h0,        2'b10, 1'b0, 1,  32'h12345678, 1'b1, 1'b0, 3,  4'b0111, 32'h12345678};
        vt[9]  = '{"ld_stall15",   1'b0, 32'h4008, 32'h0,        2'b10, 1'b1, 15, 32'h0BADC0DE, 1'b1, 1'b0, 17, 4'b1111, 32'h0BADC0DE};
        vt[10] = '{"ld_stall16",   1'b0, 32'h400C, 32'h0,        2'b10, 1'b0, 16, 32'h55AA55AA, 1'b1, 1'b1, 17, 4'b0111, 32'h0};
        vt[11] = '{"st_shalf",     1'b1, 32'h4000, 32'hFFFF8001, 2'b01, 1'b1, 2,  32'h0,        1'b1, 1'b0, 4,  4'b1011, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset addr", dmem_addr, 32'h0);
        check("reset wdata", dmem_write_data, 32'h0);
        check("reset rdata", rsp_rdata, 32'h0);
        check("reset ctl", {25'b0, rsp_valid, rsp_fault, dmem_memread, dmem_memwrite, dmem_sign_mask}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++)
            run_txn(vt[i].name, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].sz, vt[i].sgn, vt[i].sl,
                    vt[i].mdata, vt[i].exp_access, vt[i].exp_fault, vt[i].exp_lat,
                    vt[i].exp_mask, vt[i].exp_rdata);

        // Long stall: fault at WAIT entry + 16, then ready only once the memory drops stall.
        run_txn("ld_timeout", 1'b0, 32'h5000, 32'h0, 2'b10, 1'b0, 40, 32'h77777777,
                1'b1, 1'b1, 17, 4'b0111, 32'h0);
        bad = 0; cyc = 0;
        while (dmem_clk_stall && cyc < 100) begin
            @(negedge clk);
            if (dmem_clk_stall && req_ready) bad++;
            cyc++;
        end
        check("timeout ready_low", 32'(bad), 32'd0);
        check("timeout ready_back", 32'(req_ready), 32'd1);

        // Reset during WAIT with the memory still busy.
        stall_len = 10;
        mem_q.delete();
        wait_ready("rst_mid");
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h6000; req_wdata = 32'h11112222;
        req_size = 2'b10; req_signed = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid addr", dmem_addr, 32'h0);
        check("rst_mid wdata", dmem_write_data, 32'h0);
        check("rst_mid rdata", rsp_rdata, 32'h0);
        check("rst_mid ctl", {23'b0, rsp_valid, rsp_fault, dmem_memread, dmem_memwrite, req_ready,
                              dmem_sign_mask}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0; bad_rsp = 0; cyc = 0;
        while (dmem_clk_stall && cyc < 100) begin
            if (req_ready) bad++;
            if (rsp_valid) bad_rsp++;
            @(negedge clk);
            cyc++;
        end
        check("rst_mid ready_back", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) bad_rsp++;
        end
        check("rst_mid ready_low", 32'(bad), 32'd0);
        check("rst_mid no_rsp", 32'(bad_rsp), 32'd0);
        $display("txn rst_mid aborted load at 00006000 ready_violations=%0d stray_rsp=%0d", bad, bad_rsp);

`ifdef LSU_MISALIGN_SPLIT_EN
        stall_len = 2;
        mem_q.delete();
        mem_q.push_back(32'hAB000000);
        mem_q.push_back(32'h000000CD);
        wait_ready("split");
        rd_cnt = 0; wr_cnt = 0; max_run = 0;
        rd_addr_q.delete();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h7003; req_size = 2'b01; req_signed = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("split latency", 32'(cyc), 32'd9);
        check("split fault", 32'(rsp_fault), 32'd0);
        check("split rdata", rsp_rdata, 32'hFFFFCDAB);
        check("split nreads", 32'(rd_cnt), 32'd2);
        check("split strobe_len", 32'(max_run), 32'd1);
        if (rd_addr_q.size() == 2) begin
            check("split addr0", rd_addr_q[0], 32'h7000);
            check("split addr1", rd_addr_q[1], 32'h7004);
        end
        $display("txn split half@00007003 lat=%0d rdata=%h", cyc, rsp_rdata);
`endif

        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            sg = 1'($urandom);
            d  = $urandom;
            m  = $urandom;
            sl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(1, 5));
`ifdef LSU_MISALIGN_SPLIT_EN
            if (!wr && (((sz == 2'b01) && (a[1:0] == 2'b11)) || ((sz == 2'b10) && (a[1:0] != 2'b00))))
                a[1:0] = 2'b00;
`endif
            model(a, sz, sg, sl, acc, flt, lat, mk);
            run_txn($sformatf("rand%0d", i), wr, a, d, sz, sg, sl, m, acc, flt, lat, mk,
                    (wr || flt) ? 32'h0 : m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
